// File: rtl/fir_seq_pkg.sv
// Shared constants and FSM encoding for the FIR sequencing controller.
package fir_seq_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 10;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Stream-side bundle of the FIR sequencer: host X push, FIR in/out AXI-Stream, host Y pop.
interface fir_seq_ctrl_if #(
  parameter int DATA_W = fir_seq_pkg::DEF_DATA_W
) ();

  logic              x_wr_valid;
  logic [DATA_W-1:0] x_wr_data;
  logic              x_wr_ready;

  logic              ss_tvalid;
  logic [DATA_W-1:0] ss_tdata;
  logic              ss_tlast;
  logic              ss_tready;

  logic              sm_tvalid;
  logic [DATA_W-1:0] sm_tdata;
  logic              sm_tlast;
  logic              sm_tready;

  logic              y_rd_valid;
  logic [DATA_W-1:0] y_rd_data;
  logic              y_rd_ready;

  // The controller side drives the stream outputs and all ready/valid it owns.
  modport master (
    input  x_wr_valid, x_wr_data,
    output x_wr_ready,
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready,
    input  sm_tvalid, sm_tdata, sm_tlast,
    output sm_tready,
    output y_rd_valid, y_rd_data,
    input  y_rd_ready
  );

  modport slave (
    output x_wr_valid, x_wr_data,
    input  x_wr_ready,
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready,
    output sm_tvalid, sm_tdata, sm_tlast,
    input  sm_tready,
    input  y_rd_valid, y_rd_data,
    output y_rd_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; storage is cleared on reset so the
// head reads zero until the first push.
module sync_fifo #(
  parameter int DATA_W = fir_seq_pkg::DEF_DATA_W,
  parameter int DEPTH  = fir_seq_pkg::DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              push;
  logic              pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = wr_valid && !full;
  assign pop     = rd_ready && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequences one FIR run: starts the core, streams len X samples into it and
// collects len Y samples back, tracking latency and TLAST consistency.
module fir_seq_ctrl
  import fir_seq_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             tlast_err,
  output logic [31:0]      cycle_cnt,
  output logic             fir_ap_start,
  input  logic             fir_ap_idle,
  fir_seq_ctrl_if.master   bus
);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_m1;
  logic [LEN_W-1:0]  x_sent;
  logic [LEN_W-1:0]  y_recv;
  logic              rst_done;
  logic              in_run;
  logic              ss_beat;
  logic              sm_beat;
  logic              x_push;
  logic              x_full;
  logic              x_empty;
  logic              y_full;
  logic              y_empty;
  logic [DATA_W-1:0] x_head;
  logic [DATA_W-1:0] y_head;

  assign in_run = (state == ST_RUN);
  assign len_m1 = len - LEN_W'(1);

  assign bus.ss_tvalid  = in_run && !x_empty && (x_sent < len);
  assign bus.ss_tdata   = x_head;
  assign bus.ss_tlast   = in_run && (x_sent == len_m1);
  assign bus.sm_tready  = in_run && !y_full && (y_recv < len);
  assign bus.x_wr_ready = rst_done && !x_full;
  assign bus.y_rd_valid = !y_empty;
  assign bus.y_rd_data  = y_head;

  assign ss_beat = bus.ss_tvalid && bus.ss_tready;
  assign sm_beat = bus.sm_tvalid && bus.sm_tready;
  assign x_push  = bus.x_wr_valid && rst_done;

  // Holds x_wr_ready low until the first edge after reset is released.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_x_fifo (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .wr_valid (x_push),
    .wr_data  (bus.x_wr_data),
    .full     (x_full),
    .rd_ready (ss_beat),
    .rd_data  (x_head),
    .empty    (x_empty)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_y_fifo (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .wr_valid (sm_beat),
    .wr_data  (bus.sm_tdata),
    .full     (y_full),
    .rd_ready (bus.y_rd_ready),
    .rd_data  (y_head),
    .empty    (y_empty)
  );

  // The last Y beat moves straight to DONE, so cycle_cnt covers START through that beat.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state        <= ST_IDLE;
      len          <= '0;
      x_sent       <= '0;
      y_recv       <= '0;
      cycle_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tlast_err    <= 1'b0;
      fir_ap_start <= 1'b0;
    end else begin
      if (ss_beat) begin
        x_sent <= x_sent + LEN_W'(1);
      end
      if (sm_beat) begin
        y_recv <= y_recv + LEN_W'(1);
        if (bus.sm_tlast != (y_recv == len_m1)) begin
          tlast_err <= 1'b1;
        end
      end
      if ((state == ST_START) || (state == ST_RUN)) begin
        cycle_cnt <= sat_inc(cycle_cnt);
      end

      case (state)
        ST_IDLE: begin
          if (cfg_start && (cfg_len != '0) && fir_ap_idle) begin
            state        <= ST_START;
            len          <= cfg_len;
            x_sent       <= '0;
            y_recv       <= '0;
            cycle_cnt    <= '0;
            done         <= 1'b0;
            tlast_err    <= 1'b0;
            busy         <= 1'b1;
            fir_ap_start <= 1'b1;
          end
        end
        ST_START: begin
          fir_ap_start <= 1'b0;
          state        <= ST_RUN;
        end
        ST_RUN: begin
          if (sm_beat && (y_recv == len_m1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a one-cycle-latency FIR stand-in (y = 3x+1)
// looping ss back to sm.
module tb_fir_seq_ctrl;

  localparam int DATA_W     = 32;
  localparam int LEN_W      = 10;
  localparam int FIFO_DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             busy;
  logic             done;
  logic             tlast_err;
  logic [31:0]      cycle_cnt;
  logic             fir_ap_start;
  logic             fir_ap_idle = 1'b1;

  fir_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

  fir_seq_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .axis_clk     (clk),
    .axis_rst_n   (rst_n),
    .cfg_start    (cfg_start),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .done         (done),
    .tlast_err    (tlast_err),
    .cycle_cnt    (cycle_cnt),
    .fir_ap_start (fir_ap_start),
    .fir_ap_idle  (fir_ap_idle),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] x_feed_q[$];
  logic [31:0] fir_q[$];
  logic [31:0] ss_seen[$];
  logic [31:0] y_got[$];
  logic [31:0] exp_in[$];
  int          feed_period = 1;
  int          feed_timer  = 0;
  int          fir_out_idx = 0;
  int          run_len     = 1;
  int          err_beat    = -1;
  int          ap_pulses   = 0;
  int          ss_last_pos = 0;
  longint      cyc         = 0;
  longint      start_cyc   = 0;
  longint      last_sm_cyc = 0;
  bit          y_ready_en  = 1'b1;
  bit          start_req   = 1'b0;
  logic [LEN_W-1:0] start_len = '0;

  function automatic logic [31:0] firModel(input logic [31:0] x);
    return x * 32'd3 + 32'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs after the falling edge, then log what the next rising edge will transfer.
  task automatic applyStimulus();
    int tl;
    @(negedge clk);
    cfg_start      = start_req;
    cfg_len        = start_len;
    start_req      = 1'b0;
    bus.x_wr_valid = (x_feed_q.size() > 0) && (feed_timer == 0);
    bus.x_wr_data  = (x_feed_q.size() > 0) ? x_feed_q[0] : 32'd0;
    tl             = (err_beat >= 0) ? err_beat : run_len - 1;
    bus.sm_tvalid  = (fir_q.size() > 0);
    bus.sm_tdata   = (fir_q.size() > 0) ? firModel(fir_q[0]) : 32'd0;
    bus.sm_tlast   = (fir_q.size() > 0) && (fir_out_idx == tl);
    bus.ss_tready  = 1'b1;
    bus.y_rd_ready = y_ready_en;
    #1;
    if (bus.x_wr_valid && bus.x_wr_ready) begin
      void'(x_feed_q.pop_front());
      feed_timer = feed_period - 1;
    end else if (feed_timer > 0) begin
      feed_timer--;
    end
    if (bus.ss_tvalid && bus.ss_tready) begin
      ss_seen.push_back(bus.ss_tdata);
      if (bus.ss_tlast) ss_last_pos = ss_seen.size();
      fir_q.push_back(bus.ss_tdata);
    end
    if (bus.sm_tvalid && bus.sm_tready) begin
      void'(fir_q.pop_front());
      fir_out_idx++;
      last_sm_cyc = cyc;
    end
    if (bus.y_rd_valid && bus.y_rd_ready) y_got.push_back(bus.y_rd_data);
    if (fir_ap_start) begin
      ap_pulses++;
      start_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic feedWords(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      x_feed_q.push_back(base + 32'(i));
      exp_in.push_back(base + 32'(i));
    end
  endtask

  task automatic prefill(input logic [31:0] base, input int n);
    int k = 0;
    feed_period = 1;
    feedWords(base, n);
    while (x_feed_q.size() > 0 && k < 100) begin
      applyStimulus();
      k++;
    end
    checkOutput("prefill_accepted", 64'(x_feed_q.size()), 64'd0);
  endtask

  // Returns during the START cycle of the accepted run.
  task automatic startRun(input int len);
    start_req   = 1'b1;
    start_len   = LEN_W'(len);
    run_len     = len;
    fir_out_idx = 0;
    ap_pulses   = 0;
    ss_last_pos = 0;
    ss_seen.delete();
    y_got.delete();
    applyStimulus();
    applyStimulus();
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic drainY(input string tag);
    int n = 0;
    while (bus.y_rd_valid && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_y_drained"}, 64'(bus.y_rd_valid), 64'd0);
  endtask

  task automatic checkRun(input string tag, input int len);
    logic [63:0] got;
    checkOutput({tag, "_ss_count"}, 64'(ss_seen.size()), 64'(len));
    checkOutput({tag, "_ss_tlast_pos"}, 64'(ss_last_pos), 64'(len));
    checkOutput({tag, "_y_count"}, 64'(y_got.size()), 64'(len));
    for (int i = 0; i < len; i++) begin
      got = (i < ss_seen.size()) ? 64'(ss_seen[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
      checkOutput($sformatf("%s_ss%0d", tag, i), got, 64'(exp_in[i]));
      got = (i < y_got.size()) ? 64'(y_got[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
      checkOutput($sformatf("%s_y%0d", tag, i), got, 64'(firModel(exp_in[i])));
    end
    for (int i = 0; i < len; i++) void'(exp_in.pop_front());
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_tlast_err"}, 64'(tlast_err), 64'd0);
    checkOutput({tag, "_ap_start"}, 64'(fir_ap_start), 64'd0);
    checkOutput({tag, "_ss_tvalid"}, 64'(bus.ss_tvalid), 64'd0);
    checkOutput({tag, "_ss_tlast"}, 64'(bus.ss_tlast), 64'd0);
    checkOutput({tag, "_sm_tready"}, 64'(bus.sm_tready), 64'd0);
    checkOutput({tag, "_x_wr_ready"}, 64'(bus.x_wr_ready), 64'd0);
    checkOutput({tag, "_y_rd_valid"}, 64'(bus.y_rd_valid), 64'd0);
    checkOutput({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    checkOutput({tag, "_ss_tdata"}, 64'(bus.ss_tdata), 64'd0);
    checkOutput({tag, "_y_rd_data"}, 64'(bus.y_rd_data), 64'd0);
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    bus.x_wr_valid = 1'b0;
    bus.x_wr_data  = '0;
    bus.ss_tready  = 1'b1;
    bus.sm_tvalid  = 1'b0;
    bus.sm_tdata   = '0;
    bus.sm_tlast   = 1'b0;
    bus.y_rd_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkResetValues("por");
    rst_n = 1'b1;
    checkOutput("ready_before_edge", 64'(bus.x_wr_ready), 64'd0);
    applyStimulus();
    checkOutput("ready_after_release", 64'(bus.x_wr_ready), 64'd1);

    // Prefilled len=8 run with an always-ready sink.
    y_ready_en = 1'b1;
    prefill(32'd1, 8);
    applyStimulus();
    checkOutput("x_full_ready_low", 64'(bus.x_wr_ready), 64'd0);
    startRun(8);
    checkOutput("s1_ap_start", 64'(fir_ap_start), 64'd1);
    checkOutput("s1_busy_start", 64'(busy), 64'd1);
    waitDone("s1", 100);
    checkOutput("s1_busy_in_done", 64'(busy), 64'd1);
    checkOutput("s1_cycle_cnt", 64'(cycle_cnt), 64'd10);
    checkOutput("s1_cycle_span", 64'(cycle_cnt), 64'(last_sm_cyc - start_cyc + 1));
    applyStimulus();
    checkOutput("s1_busy_idle", 64'(busy), 64'd0);
    checkOutput("s1_done_sticky", 64'(done), 64'd1);
    checkOutput("s1_ap_pulses", 64'(ap_pulses), 64'd1);
    checkOutput("s1_tlast_err", 64'(tlast_err), 64'd0);
    drainY("s1");
    checkRun("s1", 8);

    // Early sm_tlast on beat 5, plus a start request in the middle of the run.
    prefill(32'h100, 8);
    err_beat = 4;
    startRun(8);
    repeat (3) applyStimulus();
    start_req = 1'b1;
    start_len = LEN_W'(8);
    waitDone("s2", 100);
    checkOutput("s2_tlast_err", 64'(tlast_err), 64'd1);
    applyStimulus();
    checkOutput("s2_ap_pulses", 64'(ap_pulses), 64'd1);
    err_beat = -1;
    drainY("s2");
    checkRun("s2", 8);

    // Starts that must be ignored: zero length, then FIR not idle.
    ap_pulses = 0;
    start_req = 1'b1;
    start_len = '0;
    repeat (3) applyStimulus();
    checkOutput("s3_len0_busy", 64'(busy), 64'd0);
    checkOutput("s3_len0_ap", 64'(ap_pulses), 64'd0);
    checkOutput("s3_len0_done_kept", 64'(done), 64'd1);
    checkOutput("s3_len0_err_kept", 64'(tlast_err), 64'd1);
    fir_ap_idle = 1'b0;
    start_req   = 1'b1;
    start_len   = LEN_W'(4);
    repeat (3) applyStimulus();
    checkOutput("s3_notidle_busy", 64'(busy), 64'd0);
    checkOutput("s3_notidle_ap", 64'(ap_pulses), 64'd0);
    fir_ap_idle = 1'b1;

    // The next accepted start clears tlast_err.
    prefill(32'h180, 4);
    startRun(4);
    checkOutput("s4_err_cleared", 64'(tlast_err), 64'd0);
    checkOutput("s4_done_cleared", 64'(done), 64'd0);
    waitDone("s4", 100);
    applyStimulus();
    checkOutput("s4_tlast_err", 64'(tlast_err), 64'd0);
    drainY("s4");
    checkRun("s4", 4);

    // len=64 from an empty X FIFO, slow host, Y held until it fills.
    feed_period = 3;
    feed_timer  = 0;
    feedWords(32'd1000, 64);
    y_ready_en = 1'b0;
    startRun(64);
    k = 0;
    while (fir_out_idx < 8 && k < 300) begin
      applyStimulus();
      k++;
    end
    repeat (6) applyStimulus();
    checkOutput("s5_sm_tready_low", 64'(bus.sm_tready), 64'd0);
    checkOutput("s5_sm_beats_held", 64'(fir_out_idx), 64'd8);
    checkOutput("s5_y_valid", 64'(bus.y_rd_valid), 64'd1);
    y_ready_en = 1'b1;
    waitDone("s5", 1500);
    applyStimulus();
    drainY("s5");
    checkRun("s5", 64);
    feed_period = 1;

    // Reset asserted mid-run at x_sent=3 with Y holding data.
    y_ready_en = 1'b0;
    prefill(32'h200, 8);
    startRun(8);
    k = 0;
    while (ss_seen.size() < 3 && k < 50) begin
      applyStimulus();
      k++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("s6");
    fir_q.delete();
    x_feed_q.delete();
    exp_in.delete();
    feed_timer = 0;
    repeat (2) applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("s6_ready_back", 64'(bus.x_wr_ready), 64'd1);
    checkOutput("s6_y_empty", 64'(bus.y_rd_valid), 64'd0);
    y_ready_en = 1'b1;
    prefill(32'h300, 4);
    startRun(4);
    waitDone("s6", 100);
    applyStimulus();
    drainY("s6");
    checkRun("s6", 4);

    // Three back-to-back len=64 runs, host streaming one word per cycle.
    for (int r = 0; r < 3; r++) begin
      checkOutput($sformatf("s7_r%0d_done_before", r), 64'(done), 64'd1);
      feedWords(32'h1000 * 32'(r + 1), 64);
      startRun(64);
      checkOutput($sformatf("s7_r%0d_done_cleared", r), 64'(done), 64'd0);
      waitDone($sformatf("s7_r%0d", r), 600);
      checkOutput($sformatf("s7_r%0d_cycle_cnt", r), 64'(cycle_cnt), 64'd66);
      checkOutput($sformatf("s7_r%0d_cycle_span", r), 64'(cycle_cnt), 64'(last_sm_cyc - start_cyc + 1));
      applyStimulus();
      drainY($sformatf("s7_r%0d", r));
      checkRun($sformatf("s7_r%0d", r), 64);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the X and Y sample words.
REQ-002 Parameter FIFO_DEPTH, default 8, entries in each of the X and Y FIFOs (power of 2, >=2).
REQ-003 Parameter LEN_W, default 10, width of the sample-count field.
REQ-004 axis_clk  input  1  single clock; all logic on its rising edge.
REQ-005 axis_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 cfg_start  input  1  one-cycle run request.
REQ-007 cfg_len  input  LEN_W  samples per run, sampled when a start is accepted.
REQ-008 busy, done, tlast_err  output  1 each  status: run active, run complete (sticky), TLAST mismatch (sticky).
REQ-009 cycle_cnt  output  32  run latency in cycles.
REQ-010 x_wr_valid, x_wr_data[DATA_W], x_wr_ready  in/in/out  host push into X FIFO.
REQ-011 ss_tvalid, ss_tdata[DATA_W], ss_tlast, ss_tready  out/out/out/in  AXI-Stream to FIR input.
REQ-012 sm_tvalid, sm_tdata[DATA_W], sm_tlast, sm_tready  in/in/in/out  AXI-Stream from FIR output.
REQ-013 y_rd_valid, y_rd_data[DATA_W], y_rd_ready  out/out/in  host pop from Y FIFO.
REQ-014 fir_ap_start  output  1  start pulse to FIR; fir_ap_idle  input  1  FIR idle status.

Function
REQ-015 FSM states IDLE, START, RUN, DONE; reset state IDLE.
REQ-016 IDLE: start accepted when cfg_start=1, cfg_len!=0 and fir_ap_idle=1; on acceptance latch len, clear x_sent, y_recv, cycle_cnt, done, tlast_err, go START.
REQ-017 cfg_start with cfg_len=0, with fir_ap_idle=0, or outside IDLE is ignored with no state change.
REQ-018 START: fir_ap_start=1 for exactly one cycle; next state RUN; cycle_cnt counts from this cycle.
REQ-019 RUN: ss_tvalid = X FIFO non-empty AND x_sent<len; ss_tdata = X FIFO head; ss_tlast = (x_sent==len-1).
REQ-020 Beat on ss when ss_tvalid&ss_tready: pop X FIFO, x_sent+1; ss_tvalid/ss_tdata hold while stalled.
REQ-021 sm_tready = (state==RUN) AND Y FIFO not full AND y_recv<len; each sm beat pushes sm_tdata into Y FIFO, y_recv+1.
REQ-022 tlast_err set if sm_tlast=1 on beat y_recv!=len-1, or sm_tlast=0 on beat y_recv==len-1.
REQ-023 RUN -> DONE in the cycle after the beat with y_recv reaching len.
REQ-024 DONE: lasts one cycle, sets done=1, freezes cycle_cnt, returns to IDLE; done stays 1 until next accepted start.
REQ-025 busy=1 in START, RUN, DONE; 0 in IDLE.
REQ-026 cycle_cnt increments once per cycle in START and RUN, saturates at 32'hFFFFFFFF.
REQ-027 x_wr_ready = X FIFO not full, accepted in every state (prefill allowed); push and pop in same cycle both take effect.
REQ-028 y_rd_valid = Y FIFO non-empty, y_rd_data = head; pop on y_rd_valid&y_rd_ready in every state; push and pop in same cycle both take effect.
REQ-029 Surplus X entries beyond len remain queued for the next run; FIFOs are never flushed except by reset.
REQ-030 x_sent, y_recv are LEN_W wide; no wrap since both stop at len.

Reset
REQ-031 On axis_rst_n=0 (any state, mid-run included): state IDLE, both FIFOs empty, all counters 0.
REQ-032 Reset values: busy, done, tlast_err, fir_ap_start, ss_tvalid, ss_tlast, sm_tready, x_wr_ready, y_rd_valid = 0; cycle_cnt, ss_tdata, y_rd_data = 0.
REQ-033 x_wr_ready rises the first cycle after reset release.

Structure
REQ-034 Package fir_seq_pkg holds the FSM state enum and default DATA_W, LEN_W, FIFO_DEPTH constants.
REQ-035 One sub-module sync_fifo (DATA_W x FIFO_DEPTH, full/empty flags, first-word-fall-through), instantiated for X and Y.

Verification
REQ-036 Prefill 8 X words 1..8, start len=8, sink always ready -> fir_ap_start one pulse, ss carries 1..8 with ss_tlast on 8, done=1 after 8th sm beat.
REQ-037 Start len=64 with empty X FIFO, host feeds one word every 3 cycles, y_rd_ready=0 until Y full -> sm_tready drops at 8 entries, no data loss, 64 outputs read in order.
REQ-038 sm_tlast asserted on beat 5 of len=8 -> tlast_err=1, run still completes, done=1; next start clears tlast_err.
REQ-039 cfg_start with cfg_len=0, and with fir_ap_idle=0 -> busy stays 0, fir_ap_start stays 0.
REQ-040 Assert axis_rst_n=0 at x_sent=3 of len=8 -> all outputs at REQ-032 values, FIFOs empty; subsequent len=4 run completes normally.
REQ-041 Three back-to-back len=64 runs -> cycle_cnt per run equals START-to-last-sm-beat cycle count, done toggles 0->1 each run.
